apb_regfile: RTL and testbench

- Parametrised APB slave register file. Successor to the fixed 5-write/3-read APB register block.
- Configurable counts of read/write (RW) control registers and read-only (RO) status registers, plus configurable wait states.
- Address-error reporting via PSLVERR, a per-register write-pulse output, and a single registered read-data path.
- Sits between the APB interconnect and peripheral control/status logic.

---
 rtl/apb_regfile_pkg.sv | 33 +++
 rtl/apb_regfile_cell.sv | 35 +++
 rtl/apb_regfile.sv | 146 ++++++++++++++
 tb/tb_apb_regfile.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_regfile_pkg.sv
// Shared types, decode helper and elaboration-check macro for apb_regfile.
// Optional byte strobes are enabled by defining APB_REGFILE_PSTRB_EN.
`ifndef APB_REGFILE_CHECK
`define APB_REGFILE_CHECK(label, cond, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end
`endif

package apb_regfile_pkg;

  localparam int CNTW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [CNTW-1:0] idx;
  } ro_hit_t;

  // Maps a register index onto the RO window; idx is only meaningful when valid.
  function automatic ro_hit_t ro_index(input int addr, input int base, input int num);
    ro_hit_t h;
    h.valid = (addr >= base) && (addr < base + num);
    h.idx   = h.valid ? CNTW'(addr - base) : '0;
    return h;
  endfunction

endpackage

// File: rtl/apb_regfile_cell.sv
// One RW register with byte strobes, reset value and a registered write pulse.
module apb_regfile_cell
  import apb_regfile_pkg::*;
#(
  parameter int                DWIDTH    = 8,
  parameter int                NB        = (DWIDTH + 7) / 8,
  parameter logic [DWIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NB-1:0]     strb,
  input  logic [DWIDTH-1:0] d,
  output logic [DWIDTH-1:0] q,
  output logic              wr
);

  logic [DWIDTH-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DWIDTH; i++) mask[i] = strb[i/8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= RESET_VAL;
      wr <= 1'b0;
    end else begin
      wr <= en && (|strb);
      if (en) q <= (q & ~mask) | (d & mask);
    end
  end

endmodule

// File: rtl/apb_regfile.sv
// Parametrised APB register file: NUM_RW control registers, NUM_RO status inputs,
// WAIT_STATES access-phase stalls. Define APB_REGFILE_PSTRB_EN to add PSTRB byte strobes.
module apb_regfile
  import apb_regfile_pkg::*;
#(
  parameter int                AWIDTH      = 4,
  parameter int                DWIDTH      = 8,
  parameter int                NUM_RW      = 5,
  parameter int                NUM_RO      = 3,
  parameter int                RO_BASE     = 8,
  parameter int                WAIT_STATES = 0,
  parameter logic [DWIDTH-1:0] RW_RESET    = '0
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [AWIDTH-1:0]        PADDR,
  input  logic [DWIDTH-1:0]        PWDATA,
`ifdef APB_REGFILE_PSTRB_EN
  input  logic [DWIDTH/8-1:0]      PSTRB,
`endif
  output logic [DWIDTH-1:0]        PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [NUM_RW*DWIDTH-1:0] regw_out,
  output logic [NUM_RW-1:0]        regw_wr,
  input  logic [NUM_RO*DWIDTH-1:0] regr_in
);

  localparam int NB = (DWIDTH + 7) / 8;

  `APB_REGFILE_CHECK(chk_num_rw, (NUM_RW >= 1) && (NUM_RW <= 16), "NUM_RW must be 1..16")
  `APB_REGFILE_CHECK(chk_num_ro, (NUM_RO >= 1) && (NUM_RO <= 16), "NUM_RO must be 1..16")
  `APB_REGFILE_CHECK(chk_ro_base, (RO_BASE >= NUM_RW) && (RO_BASE + NUM_RO <= 2**AWIDTH), "RO window overlaps RW or exceeds PADDR range")
  `APB_REGFILE_CHECK(chk_wait, (WAIT_STATES >= 0) && (WAIT_STATES <= 15), "WAIT_STATES must be 0..15")
`ifdef APB_REGFILE_PSTRB_EN
  `APB_REGFILE_CHECK(chk_dwidth, (DWIDTH % 8) == 0, "DWIDTH must be a multiple of 8 with PSTRB")
`endif

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [AWIDTH-1:0] addr_q;
  logic              wr_q;

  logic [AWIDTH-1:0] addr_sel;
  logic              wr_sel;
  logic              rw_hit;
  ro_hit_t           ro;
  logic              err;
  logic [DWIDTH-1:0] rdata;
  logic [NB-1:0]     strb;
  logic              wr_fire;

  // In IDLE the bus itself is decoded (zero-wait capture); later the setup latch is used.
  always_comb begin
    addr_sel = (state == IDLE) ? PADDR : addr_q;
    wr_sel   = (state == IDLE) ? PWRITE : wr_q;
    rw_hit   = int'(addr_sel) < NUM_RW;
    ro       = ro_index(int'(addr_sel), RO_BASE, NUM_RO);
    err      = !(rw_hit || ro.valid) || (wr_sel && ro.valid);
`ifdef APB_REGFILE_PSTRB_EN
    err      = err || (!wr_sel && (|PSTRB));
`endif
    rdata    = '0;
    if (!wr_sel && !err) begin
      for (int k = 0; k < NUM_RW; k++)
        if (int'(addr_sel) == k) rdata = regw_out[k*DWIDTH +: DWIDTH];
      for (int k = 0; k < NUM_RO; k++)
        if (ro.valid && (int'(ro.idx) == k)) rdata = regr_in[k*DWIDTH +: DWIDTH];
    end
  end

`ifdef APB_REGFILE_PSTRB_EN
  assign strb = PSTRB;
`else
  assign strb = '1;
`endif

  assign wr_fire = (state == DONE) && PSEL && PENABLE && PWRITE && wr_q && !PSLVERR;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_q <= PADDR;
            wr_q   <= PWRITE;
            if (WAIT_STATES == 0) begin
              state   <= DONE;
              PREADY  <= 1'b1;
              PSLVERR <= err;
              PRDATA  <= rdata;
            end else begin
              state <= WAIT;
              cnt   <= CNTW'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (cnt == CNTW'(1)) begin
            state   <= DONE;
            PREADY  <= 1'b1;
            PSLVERR <= err;
            PRDATA  <= rdata;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_cell
    apb_regfile_cell #(
      .DWIDTH   (DWIDTH),
      .NB       (NB),
      .RESET_VAL(RW_RESET)
    ) u_cell (
      .clk (PCLK),
      .rst (PRESET),
      .en  (wr_fire && (int'(addr_q) == k)),
      .strb(strb),
      .d   (PWDATA),
      .q   (regw_out[k*DWIDTH +: DWIDTH]),
      .wr  (regw_wr[k])
    );
  end

endmodule

// File: tb/tb_apb_regfile.sv
// Self-checking bench for apb_regfile: zero-wait and 3-wait instances, plus a
// 16-bit instance exercising byte strobes when APB_REGFILE_PSTRB_EN is defined.
module tb_apb_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        psel[2], penable[2], pwrite[2];
  logic [3:0]  paddr[2];
  logic [7:0]  pwdata[2], prdata[2];
  logic        pready[2], pslverr[2];
  logic [39:0] regw_out[2];
  logic [4:0]  regw_wr[2];
  logic [23:0] regr_in[2];
`ifdef APB_REGFILE_PSTRB_EN
  logic        pstrb[2];
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  apb_regfile #(.WAIT_STATES(0)) dut (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]),
`ifdef APB_REGFILE_PSTRB_EN
    .PSTRB(pstrb[0]),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .regw_out(regw_out[0]), .regw_wr(regw_wr[0]), .regr_in(regr_in[0])
  );

  apb_regfile #(.WAIT_STATES(3), .RW_RESET(8'h5A)) dut_ws (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]),
`ifdef APB_REGFILE_PSTRB_EN
    .PSTRB(pstrb[1]),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .regw_out(regw_out[1]), .regw_wr(regw_wr[1]), .regr_in(regr_in[1])
  );

`ifdef APB_REGFILE_PSTRB_EN
  logic        q_sel, q_en, q_wr, q_ready, q_err;
  logic [3:0]  q_addr;
  logic [15:0] q_wdata, q_rdata;
  logic [1:0]  q_strb;
  logic [79:0] q_regw;
  logic [4:0]  q_wrp;
  logic [47:0] q_regr;

  apb_regfile #(.DWIDTH(16)) dut16 (
    .PCLK(clk), .PRESET(rst), .PSEL(q_sel), .PENABLE(q_en), .PWRITE(q_wr),
    .PADDR(q_addr), .PWDATA(q_wdata), .PSTRB(q_strb),
    .PRDATA(q_rdata), .PREADY(q_ready), .PSLVERR(q_err),
    .regw_out(q_regw), .regw_wr(q_wrp), .regr_in(q_regr)
  );
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Setup on one cycle, access from the next; returns on the cycle PREADY is high.
  task automatic xfer(input int u, input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                      output logic [7:0] rdata, output logic err, output int cyc);
    @(negedge clk);
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = addr; pwdata[u] = wdata;
`ifdef APB_REGFILE_PSTRB_EN
    pstrb[u] = wr;
`endif
    @(negedge clk);
    penable[u] = 1'b1;
    cyc = 1;
    while (!pready[u] && cyc < 40) begin
      check("prdata_zero_while_stalled", {56'b0, prdata[u]}, 64'h0);
      @(negedge clk);
      cyc++;
    end
    if (!pready[u]) check("pready_timeout", {63'b0, pready[u]}, 64'h1);
    rdata = prdata[u];
    err   = pslverr[u];
  endtask

  task automatic bus_idle(input int u);
    @(negedge clk);
    psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
  endtask

`ifdef APB_REGFILE_PSTRB_EN
  task automatic xfer16(input logic wr, input logic [3:0] addr, input logic [15:0] wdata,
                        input logic [1:0] strb, output logic [15:0] rdata, output logic err);
    int cyc;
    @(negedge clk);
    q_sel = 1'b1; q_en = 1'b0; q_wr = wr; q_addr = addr; q_wdata = wdata; q_strb = strb;
    @(negedge clk);
    q_en = 1'b1;
    cyc = 0;
    while (!q_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!q_ready) check("pready16_timeout", {63'b0, q_ready}, 64'h1);
    rdata = q_rdata;
    err   = q_err;
  endtask
`endif

  typedef struct {
    int         u;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] got_d;
    logic       got_e;
    int         got_c;
    logic [8:0] exp;
    logic       saw_ready;

    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0; paddr[u] = '0; pwdata[u] = '0;
`ifdef APB_REGFILE_PSTRB_EN
      pstrb[u] = 1'b0;
`endif
    end
    regr_in[0] = 24'h11_3C_5A;
    regr_in[1] = 24'h99_88_77;
`ifdef APB_REGFILE_PSTRB_EN
    q_sel = 1'b0; q_en = 1'b0; q_wr = 1'b0; q_addr = '0; q_wdata = '0; q_strb = '0;
    q_regr = 48'h0003_0002_0001;
`endif

    // Table: u, wr, addr, wdata, expected rdata, expected PSLVERR, access cycles.
    vecs.push_back('{0, 1'b0, 4'd0,  8'h00, 8'h00, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 4'd2,  8'h00, 8'hA5, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 4'd9,  8'h00, 8'h3C, 1'b0, 1});
    vecs.push_back('{0, 1'b1, 4'd9,  8'hFF, 8'h00, 1'b1, 1});
    vecs.push_back('{0, 1'b0, 4'd9,  8'h00, 8'h3C, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 4'd6,  8'h00, 8'h00, 1'b1, 1});
    vecs.push_back('{0, 1'b0, 4'd8,  8'h00, 8'h5A, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 4'd10, 8'h00, 8'h11, 1'b0, 1});
    vecs.push_back('{0, 1'b1, 4'd4,  8'h5E, 8'h00, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 4'd4,  8'h00, 8'h5E, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 4'd11, 8'h00, 8'h00, 1'b1, 1});
    vecs.push_back('{0, 1'b1, 4'd5,  8'h33, 8'h00, 1'b1, 1});
    vecs.push_back('{0, 1'b0, 4'd15, 8'h00, 8'h00, 1'b1, 1});
    vecs.push_back('{1, 1'b0, 4'd6,  8'h00, 8'h00, 1'b1, 4});
    vecs.push_back('{1, 1'b0, 4'd1,  8'h00, 8'h5A, 1'b0, 4});
    vecs.push_back('{1, 1'b1, 4'd1,  8'h42, 8'h00, 1'b0, 4});
    vecs.push_back('{1, 1'b0, 4'd1,  8'h00, 8'h42, 1'b0, 4});
    vecs.push_back('{1, 1'b0, 4'd9,  8'h00, 8'h88, 1'b0, 4});
    vecs.push_back('{1, 1'b1, 4'd10, 8'h12, 8'h00, 1'b1, 4});

    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_prdata%0d", u),  {56'b0, prdata[u]},   64'h0);
      check($sformatf("reset_pready%0d", u),  {63'b0, pready[u]},   64'h0);
      check($sformatf("reset_pslverr%0d", u), {63'b0, pslverr[u]},  64'h0);
      check($sformatf("reset_regw_wr%0d", u), {59'b0, regw_wr[u]},  64'h0);
    end
    check("reset_regw_out0", {24'b0, regw_out[0]}, 64'h0);
    check("reset_regw_out1", {24'b0, regw_out[1]}, 64'h5A5A5A5A5A);
    rst = 1'b0;

    // Write 0xA5 to index 2 and watch the one-cycle write pulse.
    xfer(0, 1'b1, 4'd2, 8'hA5, got_d, got_e, got_c);
    check("wr2_resp", {55'b0, got_e, got_d}, 64'h0);
    bus_idle(0);
    check("wr2_pulse", {59'b0, regw_wr[0]}, 64'h04);
    check("wr2_regw", {24'b0, regw_out[0]}, 64'h00_00_A5_00_00);
    @(negedge clk);
    check("wr2_pulse_end", {59'b0, regw_wr[0]}, 64'h0);

    // Write to an RO index: error, no pulse, nothing changes.
    xfer(0, 1'b1, 4'd9, 8'hFF, got_d, got_e, got_c);
    check("ro_wr_err", {63'b0, got_e}, 64'h1);
    bus_idle(0);
    check("ro_wr_no_pulse", {59'b0, regw_wr[0]}, 64'h0);
    check("ro_wr_regw", {24'b0, regw_out[0]}, 64'h00_00_A5_00_00);

    // Table pass, back-to-back per unit.
    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back({vecs[i].err, vecs[i].rdata});
      xfer(vecs[i].u, vecs[i].wr, vecs[i].addr, vecs[i].wdata, got_d, got_e, got_c);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_resp", i), {55'b0, got_e, got_d}, {55'b0, exp});
      check($sformatf("vec%0d_cycles", i), 64'(got_c), 64'(vecs[i].cyc));
    end
    bus_idle(0);
    bus_idle(1);
    check("table_regw0", {24'b0, regw_out[0]}, 64'h5E_00_A5_00_00);
    check("table_regw1", {24'b0, regw_out[1]}, 64'h5A_5A_5A_42_5A);

`ifdef APB_REGFILE_PSTRB_EN
    begin
      logic [15:0] r16;
      logic        e16;
      xfer16(1'b1, 4'd0, 16'h1234, 2'b11, r16, e16);
      check("strb_full_err", {63'b0, e16}, 64'h0);
      xfer16(1'b1, 4'd0, 16'hBEEF, 2'b10, r16, e16);
      check("strb_hi_err", {63'b0, e16}, 64'h0);
      xfer16(1'b0, 4'd0, 16'h0000, 2'b00, r16, e16);
      check("strb_hi_read", {47'b0, e16, r16}, 64'hBE34);
      xfer16(1'b1, 4'd0, 16'hFFFF, 2'b00, r16, e16);
      check("strb_none_err", {63'b0, e16}, 64'h0);
      @(negedge clk);
      q_sel = 1'b0; q_en = 1'b0;
      check("strb_none_pulse", {59'b0, q_wrp}, 64'h0);
      check("strb_none_regw", {48'b0, q_regw[15:0]}, 64'hBE34);
      xfer16(1'b0, 4'd0, 16'h0000, 2'b01, r16, e16);
      check("strb_read_err", {47'b0, e16, r16}, 64'h10000);
      @(negedge clk);
      q_sel = 1'b0; q_en = 1'b0;
    end
`endif

    // Write 0x77 to index 1 on the wait-state unit, abandoned in WAIT.
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 4'd1; pwdata[1] = 8'h77;
    @(negedge clk);
    penable[1] = 1'b1;
    saw_ready = pready[1];
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      saw_ready = saw_ready | pready[1];
      check($sformatf("abort_wr_pulse%0d", i), {59'b0, regw_wr[1]}, 64'h0);
      @(negedge clk);
    end
    check("abort_no_ready", {63'b0, saw_ready}, 64'h0);
    check("abort_regw1", {24'b0, regw_out[1]}, 64'h5A_5A_5A_42_5A);

    // Reset lands during the DONE cycle of a write: the write is dropped.
    xfer(1, 1'b1, 4'd3, 8'h66, got_d, got_e, got_c);
    check("rst_wr_cycles", 64'(got_c), 64'd4);
    rst = 1'b1;
    #1;
    check("rst_pready", {63'b0, pready[1]}, 64'h0);
    check("rst_regw1_now", {24'b0, regw_out[1]}, 64'h5A5A5A5A5A);
    @(negedge clk);
    rst = 1'b0;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    check("rst_regw1_after", {24'b0, regw_out[1]}, 64'h5A5A5A5A5A);
    check("rst_pulse1_after", {59'b0, regw_wr[1]}, 64'h0);
    check("rst_regw0_after", {24'b0, regw_out[0]}, 64'h0);
    check("rst_prdata1", {56'b0, prdata[1]}, 64'h0);

    // Wait-state unit still works after the reset.
    xfer(1, 1'b0, 4'd3, 8'h00, got_d, got_e, got_c);
    check("post_rst_read", {55'b0, got_e, got_d}, 64'h5A);
    bus_idle(1);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
